wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage: holds the MEM/WB pipeline register, waits for load data,
//  aligns and extends it, and selects the writeback value.
//  Drives the register file write port (WAddr_RF/WD_RF/WrEn_RF) directly.
//  Back-pressures the pipeline with stall_WB while a load waits on data memory.
//  Counts retired instructions.
// PARAMETERS
//  XLEN      32  datapath width; only 32 is supported
//  CNT_W     32  width of the retired-instruction counter
// PORTS
//  clk           in   1      clock, all state updates on posedge
//  reset         in   1      synchronous, active-high
//  valid_MEM     in   1      MEM stage presents an instruction
//  rd_MEM        in   5      destination register
//  regwen_MEM    in   1      instruction writes rd
//  wbsel_MEM     in   2      0 = ALU, 1 = load data, 2 = PC+4, 3 = reserved (ALU)
//  alu_MEM       in   32     ALU result
//  pc4_MEM       in   32     PC+4
//  funct3_MEM    in   3      load type
//  boff_MEM      in   2      load byte offset, alu_MEM[1:0]
//  dmem_rdata    in   32     raw data-memory word
//  dmem_rvalid   in   1      dmem_rdata valid this cycle
//  WAddr_RF      out  5      regfile write address
//  WD_RF         out  32     regfile write data
//  WrEn_RF       out  1      regfile write enable
//  stall_WB      out  1      WB cannot accept; upstream holds MEM
//  retired_cnt   out  CNT_W  instructions completed in WB
// BEHAVIOUR
//  - States
//    - EMPTY: no instruction held.
//    - FULL: instruction held. Substate WAIT when wbsel=1 and dmem_rvalid=0.
//  - Accept: on a posedge with stall_WB=0, the stage register loads all *_MEM fields.
//    Next state is FULL if valid_MEM=1, else EMPTY.
//  - stall_WB=1 holds the register and state. MEM is not sampled.
//  - stall_WB = FULL & wbsel==1 & ~dmem_rvalid (combinational).
//  - Completion: a FULL instruction completes in the cycle stall_WB=0.
//    - Non-loads: 1 cycle after accept.
//    - Loads: the first cycle with dmem_rvalid=1.
//  - Write outputs are combinational from the stage register and dmem inputs:
//    - WrEn_RF = FULL & regwen & (rd!=0) & ~stall_WB
//    - WAddr_RF = held rd (0 when EMPTY)
//    - WD_RF = selected value (0 when EMPTY)
//    - Writes to x0 never assert WrEn_RF.
//  - Load formatting, by funct3:
//    - 0 LB: sign-extend byte[boff].
//    - 4 LBU: zero-extend byte[boff].
//    - 1 LH: sign-extend half[boff[1]]; boff[0] is ignored.
//    - 5 LHU: zero-extend half[boff[1]].
//    - 2 LW and 3/6/7: raw word.
//  - retired_cnt increments by 1 on each completion, with or without regwen.
//    Wraps modulo 2^CNT_W.
//  - dmem_rvalid while EMPTY, or while FULL with wbsel!=1: ignored.
//  - Reset clears all state: EMPTY, retired_cnt=0, all outputs 0.
//    A pending load is dropped and never written.
//  - Simultaneous completion and accept (no stall): both happen on the same edge.
//    Back-to-back sustains 1 instr/cycle.
// CONFIGURATION
//  WB_FWD_EN defined: adds three outputs for decode-stage bypassing.
//    - fwd_valid (1) = WrEn_RF
//    - fwd_addr (5) = WAddr_RF
//    - fwd_data (32) = WD_RF
//    - fwd_valid=0 during WAIT and after reset.
//  WB_FWD_EN undefined: these ports and their logic are absent.
//    All other behaviour is identical.
// TESTING
//  1. ALU op rd=5, alu=0x1234, wbsel=0, then valid_MEM=0 -> next cycle WrEn_RF=1,
//     WAddr=5, WD=0x1234; the cycle after, WrEn=0; retired_cnt=1.
//  2. LB boff=3, rdata=0x80FF_0000, rvalid low 2 cycles then high ->
//     stall_WB=1 for 2 cycles; then WD=0xFFFF_FF80, WrEn=1, stall=0.
//  3. LHU boff=2, rdata=0xBEEF_1234, rvalid=1 -> WD=0x0000_BEEF.
//     LH with the same inputs -> WD=0xFFFF_BEEF.
//  4. JAL rd=0, pc4=0x100, wbsel=2 -> WrEn_RF=0, retired_cnt increments.
//     Same with rd=1 -> WD=0x100.
//  5. Reset asserted during WAIT -> next cycle EMPTY, stall=0, WrEn=0, cnt=0.
//     A later rvalid causes no write.
//  6. 4 back-to-back ALU ops -> 4 consecutive writes, no stall, cnt=4.
//     With WB_FWD_EN: fwd_* mirrors each write.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load alignment/extension, writeback select,
// load-wait back-pressure and retired-instruction counter. Optional bypass outputs under `WB_FWD_EN.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_MEM,
    input  logic [4:0]       rd_MEM,
    input  logic             regwen_MEM,
    input  logic [1:0]       wbsel_MEM,
    input  logic [XLEN-1:0]  alu_MEM,
    input  logic [XLEN-1:0]  pc4_MEM,
    input  logic [2:0]       funct3_MEM,
    input  logic [1:0]       boff_MEM,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             dmem_rvalid,
    output logic [4:0]       WAddr_RF,
    output logic [XLEN-1:0]  WD_RF,
    output logic             WrEn_RF,
    output logic             stall_WB,
`ifdef WB_FWD_EN
    output logic             fwd_valid,
    output logic [4:0]       fwd_addr,
    output logic [XLEN-1:0]  fwd_data,
`endif
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [4:0]        r_rd;
    logic              r_regwen;
    logic [1:0]        r_wbsel;
    logic [XLEN-1:0]   r_alu;
    logic [XLEN-1:0]   r_pc4;
    logic [2:0]        r_funct3;
    logic [1:0]        r_boff;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_full;
    logic              w_stall;
    logic              w_complete;
    logic [7:0]        w_byte [4];
    logic [7:0]        w_sel_byte;
    logic [15:0]       w_sel_half;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_value;

    assign w_full     = (r_state == S_FULL);
    assign w_stall    = w_full && (r_wbsel == 2'd1) && !dmem_rvalid;
    assign w_complete = w_full && !w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stalled: hold state; otherwise the incoming valid decides occupancy.
    always_comb begin
        w_state_next = r_state;
        if (!w_stall) begin
            w_state_next = valid_MEM ? S_FULL : S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd     <= '0;
            r_regwen <= 1'b0;
            r_wbsel  <= '0;
            r_alu    <= '0;
            r_pc4    <= '0;
            r_funct3 <= '0;
            r_boff   <= '0;
            r_cnt    <= '0;
        end else begin
            if (!w_stall) begin
                r_rd     <= rd_MEM;
                r_regwen <= regwen_MEM;
                r_wbsel  <= wbsel_MEM;
                r_alu    <= alu_MEM;
                r_pc4    <= pc4_MEM;
                r_funct3 <= funct3_MEM;
                r_boff   <= boff_MEM;
            end
            if (w_complete) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_byte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_sel_byte = w_byte[r_boff];
    assign w_sel_half = r_boff[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_load = dmem_rdata;
        case (r_funct3)
            3'd0:    w_load = {{(XLEN-8){w_sel_byte[7]}}, w_sel_byte};
            3'd4:    w_load = {{(XLEN-8){1'b0}}, w_sel_byte};
            3'd1:    w_load = {{(XLEN-16){w_sel_half[15]}}, w_sel_half};
            3'd5:    w_load = {{(XLEN-16){1'b0}}, w_sel_half};
            default: w_load = dmem_rdata;
        endcase
    end

    // Reserved select 3 falls back to the ALU result.
    always_comb begin
        w_value = r_alu;
        case (r_wbsel)
            2'd1:    w_value = w_load;
            2'd2:    w_value = r_pc4;
            default: w_value = r_alu;
        endcase
    end

    assign WrEn_RF     = w_complete && r_regwen && (r_rd != 5'd0);
    assign WAddr_RF    = w_full ? r_rd : 5'd0;
    assign WD_RF       = w_full ? w_value : '0;
    assign stall_WB    = w_stall;
    assign retired_cnt = r_cnt;

`ifdef WB_FWD_EN
    assign fwd_valid = WrEn_RF;
    assign fwd_addr  = WAddr_RF;
    assign fwd_data  = WD_RF;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: per-cycle comparison against an occupancy/queue-level
// model plus directed literal checks. Define WB_FWD_EN to also check the bypass outputs.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_MEM;
    logic [4:0]  rd_MEM;
    logic        regwen_MEM;
    logic [1:0]  wbsel_MEM;
    logic [31:0] alu_MEM;
    logic [31:0] pc4_MEM;
    logic [2:0]  funct3_MEM;
    logic [1:0]  boff_MEM;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic [4:0]  WAddr_RF;
    logic [31:0] WD_RF;
    logic        WrEn_RF;
    logic        stall_WB;
    logic [31:0] retired_cnt;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    wb_stage dut (
        .clk         (clk),
        .reset       (reset),
        .valid_MEM   (valid_MEM),
        .rd_MEM      (rd_MEM),
        .regwen_MEM  (regwen_MEM),
        .wbsel_MEM   (wbsel_MEM),
        .alu_MEM     (alu_MEM),
        .pc4_MEM     (pc4_MEM),
        .funct3_MEM  (funct3_MEM),
        .boff_MEM    (boff_MEM),
        .dmem_rdata  (dmem_rdata),
        .dmem_rvalid (dmem_rvalid),
        .WAddr_RF    (WAddr_RF),
        .WD_RF       (WD_RF),
        .WrEn_RF     (WrEn_RF),
        .stall_WB    (stall_WB),
`ifdef WB_FWD_EN
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
`endif
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    // Model: the instruction held in WB, as a record; occupancy is simply whether one is held.
    typedef struct {
        bit          held;
        int unsigned rd;
        bit          regwen;
        int unsigned wbsel;
        logic [31:0] alu;
        logic [31:0] pc4;
        int unsigned funct3;
        int unsigned boff;
    } instr_t;

    instr_t      m_ins;
    logic [31:0] m_cnt;

    function automatic logic [31:0] load_value(int unsigned f3, int unsigned boff, logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * boff)) & 32'hFF;
        h = (word >> (16 * (boff / 2))) & 32'hFFFF;
        case (f3)
            0:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            4:       return b;
            1:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            5:       return h;
            default: return word;
        endcase
    endfunction

    function automatic bit model_waiting(logic rv);
        return m_ins.held && (m_ins.wbsel == 1) && !rv;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ins.held = 1'b0;
            m_cnt      = 32'd0;
        end else if (!model_waiting(dmem_rvalid)) begin
            if (m_ins.held) m_cnt = m_cnt + 32'd1;
            m_ins.held   = valid_MEM;
            m_ins.rd     = rd_MEM;
            m_ins.regwen = regwen_MEM;
            m_ins.wbsel  = wbsel_MEM;
            m_ins.alu    = alu_MEM;
            m_ins.pc4    = pc4_MEM;
            m_ins.funct3 = funct3_MEM;
            m_ins.boff   = boff_MEM;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_stall;
            logic        e_wen;
            logic [4:0]  e_addr;
            logic [31:0] e_wd;
            e_stall = model_waiting(dmem_rvalid);
            e_addr  = m_ins.held ? 5'(m_ins.rd) : 5'd0;
            if (!m_ins.held)          e_wd = 32'd0;
            else if (m_ins.wbsel == 1) e_wd = load_value(m_ins.funct3, m_ins.boff, dmem_rdata);
            else if (m_ins.wbsel == 2) e_wd = m_ins.pc4;
            else                       e_wd = m_ins.alu;
            e_wen = m_ins.held && m_ins.regwen && (m_ins.rd != 0) && !e_stall;
            chk("model_stall", 32'(stall_WB), 32'(e_stall));
            chk("model_wren", 32'(WrEn_RF), 32'(e_wen));
            chk("model_waddr", 32'(WAddr_RF), 32'(e_addr));
            chk("model_wd", WD_RF, e_wd);
            chk("model_cnt", retired_cnt, m_cnt);
`ifdef WB_FWD_EN
            chk("model_fwd_valid", 32'(fwd_valid), 32'(e_wen));
            chk("model_fwd_addr", 32'(fwd_addr), 32'(e_addr));
            chk("model_fwd_data", fwd_data, e_wd);
`endif
        end
    end

    task automatic op(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] ws,
                      input logic [31:0] alu, input logic [31:0] pc4,
                      input logic [2:0] f3, input logic [1:0] bo);
        valid_MEM  = v;
        rd_MEM     = rd;
        regwen_MEM = rw;
        wbsel_MEM  = ws;
        alu_MEM    = alu;
        pc4_MEM    = pc4;
        funct3_MEM = f3;
        boff_MEM   = bo;
    endtask

    task automatic idle();
        op(1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [31:0] cnt_before;

    initial begin
        reset       = 1'b1;
        dmem_rdata  = 32'd0;
        dmem_rvalid = 1'b0;
        idle();
        step();
        step();
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_stall", 32'(stall_WB), 32'd0);
        chk("rst_wren", 32'(WrEn_RF), 32'd0);
        chk("rst_waddr", 32'(WAddr_RF), 32'd0);
        chk("rst_wd", WD_RF, 32'd0);
        chk("rst_cnt", retired_cnt, 32'd0);

        // 1: single ALU op
        op(1'b1, 5'd5, 1'b1, 2'd0, 32'h1234, 32'h4, 3'd2, 2'd0);
        step();
        idle();
        @(negedge clk);
        chk("alu_wren", 32'(WrEn_RF), 32'd1);
        chk("alu_waddr", 32'(WAddr_RF), 32'd5);
        chk("alu_wd", WD_RF, 32'h1234);
        step();
        @(negedge clk);
        chk("alu_after_wren", 32'(WrEn_RF), 32'd0);
        chk("alu_cnt", retired_cnt, 32'd1);

        // 2: LB byte 3 with two wait cycles
        dmem_rdata  = 32'h80FF_0000;
        dmem_rvalid = 1'b0;
        op(1'b1, 5'd6, 1'b1, 2'd1, 32'h2003, 32'h0, 3'd0, 2'd3);
        step();
        op(1'b1, 5'd7, 1'b1, 2'd0, 32'hDEAD, 32'h0, 3'd0, 2'd0);
        @(negedge clk);
        chk("lb_wait1_stall", 32'(stall_WB), 32'd1);
        chk("lb_wait1_wren", 32'(WrEn_RF), 32'd0);
        step();
        @(negedge clk);
        chk("lb_wait2_stall", 32'(stall_WB), 32'd1);
        step();
        dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("lb_stall", 32'(stall_WB), 32'd0);
        chk("lb_wd", WD_RF, 32'hFFFF_FF80);
        chk("lb_wren", 32'(WrEn_RF), 32'd1);
        step();
        dmem_rvalid = 1'b0;
        idle();
        @(negedge clk);
        chk("held_alu_after_load", WD_RF, 32'hDEAD);
        chk("lb_cnt", retired_cnt, 32'd2);
        step();

        // 3: LHU then LH, back-to-back, data already valid
        dmem_rdata  = 32'hBEEF_1234;
        dmem_rvalid = 1'b1;
        op(1'b1, 5'd8, 1'b1, 2'd1, 32'h0, 32'h0, 3'd5, 2'd2);
        step();
        op(1'b1, 5'd9, 1'b1, 2'd1, 32'h0, 32'h0, 3'd1, 2'd3);
        @(negedge clk);
        chk("lhu_wd", WD_RF, 32'h0000_BEEF);
        step();
        op(1'b1, 5'd10, 1'b1, 2'd1, 32'h0, 32'h0, 3'd0, 2'd1);
        @(negedge clk);
        chk("lh_wd", WD_RF, 32'hFFFF_BEEF);
        step();
        op(1'b1, 5'd11, 1'b1, 2'd1, 32'h0, 32'h0, 3'd4, 2'd3);
        @(negedge clk);
        chk("lb_pos_wd", WD_RF, 32'h0000_0012);
        step();
        op(1'b1, 5'd12, 1'b1, 2'd1, 32'h0, 32'h0, 3'd2, 2'd1);
        @(negedge clk);
        chk("lbu_wd", WD_RF, 32'h0000_00BE);
        step();
        idle();
        @(negedge clk);
        chk("lw_wd", WD_RF, 32'hBEEF_1234);
        step();
        dmem_rvalid = 1'b0;

        // 4: JAL to x0 and to x1, plus reserved select
        cnt_before = retired_cnt;
        op(1'b1, 5'd0, 1'b1, 2'd2, 32'h55, 32'h100, 3'd0, 2'd0);
        step();
        op(1'b1, 5'd1, 1'b1, 2'd2, 32'h55, 32'h100, 3'd0, 2'd0);
        @(negedge clk);
        chk("jal_x0_wren", 32'(WrEn_RF), 32'd0);
        step();
        op(1'b1, 5'd2, 1'b1, 2'd3, 32'hA5A5, 32'h200, 3'd0, 2'd0);
        @(negedge clk);
        chk("jal_x0_cnt", retired_cnt, cnt_before + 32'd1);
        chk("jal_x1_wd", WD_RF, 32'h100);
        chk("jal_x1_wren", 32'(WrEn_RF), 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("rsv_sel_wd", WD_RF, 32'hA5A5);
        step();

        // 5: reset while waiting on a load
        dmem_rdata = 32'h1111_2222;
        op(1'b1, 5'd13, 1'b1, 2'd1, 32'h0, 32'h0, 3'd2, 2'd0);
        step();
        idle();
        @(negedge clk);
        chk("pre_rst_stall", 32'(stall_WB), 32'd1);
        do_reset();
        @(negedge clk);
        chk("wait_rst_stall", 32'(stall_WB), 32'd0);
        chk("wait_rst_wren", 32'(WrEn_RF), 32'd0);
        chk("wait_rst_cnt", retired_cnt, 32'd0);
        dmem_rvalid = 1'b1;
        step();
        @(negedge clk);
        chk("late_rvalid_wren", 32'(WrEn_RF), 32'd0);
        dmem_rvalid = 1'b0;
        step();

        // 6: four back-to-back ALU ops
        for (int i = 1; i <= 4; i++) begin
            op(1'b1, 5'(i), 1'b1, 2'd0, 32'h100 * i, 32'h0, 3'd0, 2'd0);
            if (i > 1) begin
                @(negedge clk);
                chk("b2b_wren", 32'(WrEn_RF), 32'd1);
                chk("b2b_waddr", 32'(WAddr_RF), 32'(i - 1));
                chk("b2b_stall", 32'(stall_WB), 32'd0);
            end
            step();
        end
        idle();
        @(negedge clk);
        chk("b2b_last_waddr", 32'(WAddr_RF), 32'd4);
        chk("b2b_last_wd", WD_RF, 32'h400);
        step();
        @(negedge clk);
        chk("b2b_cnt", retired_cnt, 32'd4);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
